// File: rtl/mux_16_reg.sv
// Registered 16-to-1 word multiplexer: a balanced four-level 2:1 tree feeding
// an output register with capture enable and a one-cycle valid flag.
module mux_16_reg #(
  parameter int WIDTH = 32
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             en,
  input  logic [3:0]       select,
  input  logic [WIDTH-1:0] in0,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic [WIDTH-1:0] in3,
  input  logic [WIDTH-1:0] in4,
  input  logic [WIDTH-1:0] in5,
  input  logic [WIDTH-1:0] in6,
  input  logic [WIDTH-1:0] in7,
  input  logic [WIDTH-1:0] in8,
  input  logic [WIDTH-1:0] in9,
  input  logic [WIDTH-1:0] in10,
  input  logic [WIDTH-1:0] in11,
  input  logic [WIDTH-1:0] in12,
  input  logic [WIDTH-1:0] in13,
  input  logic [WIDTH-1:0] in14,
  input  logic [WIDTH-1:0] in15,
  output logic [WIDTH-1:0] out,
  output logic             out_valid
);

  logic [WIDTH-1:0] lvl0 [16];
  logic [WIDTH-1:0] lvl1 [8];
  logic [WIDTH-1:0] lvl2 [4];
  logic [WIDTH-1:0] lvl3 [2];
  logic [WIDTH-1:0] sel_data;

  logic [WIDTH-1:0] out_d, out_q;
  logic             valid_d, valid_q;

  always_comb begin
    lvl0[0]  = in0;
    lvl0[1]  = in1;
    lvl0[2]  = in2;
    lvl0[3]  = in3;
    lvl0[4]  = in4;
    lvl0[5]  = in5;
    lvl0[6]  = in6;
    lvl0[7]  = in7;
    lvl0[8]  = in8;
    lvl0[9]  = in9;
    lvl0[10] = in10;
    lvl0[11] = in11;
    lvl0[12] = in12;
    lvl0[13] = in13;
    lvl0[14] = in14;
    lvl0[15] = in15;
  end

  // Level n of the tree is steered by select[n-1]; even entries win on 0.
  always_comb begin
    for (int k = 0; k < 8; k++) lvl1[k] = select[0] ? lvl0[2*k+1] : lvl0[2*k];
  end

  always_comb begin
    for (int k = 0; k < 4; k++) lvl2[k] = select[1] ? lvl1[2*k+1] : lvl1[2*k];
  end

  always_comb begin
    for (int k = 0; k < 2; k++) lvl3[k] = select[2] ? lvl2[2*k+1] : lvl2[2*k];
  end

  assign sel_data = select[3] ? lvl3[1] : lvl3[0];

  // NOTE: defaults first so every path assigns both signals and no latch is inferred.
  always_comb begin
    out_d   = out_q;
    valid_d = 1'b0;
    if (en) begin
      out_d   = sel_data;
      valid_d = 1'b1;
    end
  end

  // NOTE: non-blocking assignments keep all flops updating from pre-edge values.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign out       = out_q;
  assign out_valid = valid_q;

endmodule

// File: tb/tb_mux_16_reg.sv
// Self-checking bench for mux_16_reg: directed vector table, hand-written reset
// sequences, and randomized traffic against an indexing reference model.
module tb_mux_16_reg;

  logic        clock;
  logic        reset_n;
  logic        en;
  logic [3:0]  select;
  logic [31:0] in32 [16];
  logic [7:0]  in8  [16];
  logic [31:0] out32;
  logic [7:0]  out8;
  logic        valid32, valid8;

  int n_total = 0;
  int n_pass  = 0;

  typedef struct {
    logic        en;
    logic [3:0]  sel;
    logic        wr;
    logic [3:0]  wr_idx;
    logic [31:0] wr_val;
    logic [31:0] exp_out;
    logic        exp_valid;
  } vec_t;

  vec_t vecs [$];

  initial clock = 1'b0;
  always #5 clock = ~clock;

  mux_16_reg #(.WIDTH(32)) dut32 (
    .clock(clock), .reset_n(reset_n), .en(en), .select(select),
    .in0(in32[0]),   .in1(in32[1]),   .in2(in32[2]),   .in3(in32[3]),
    .in4(in32[4]),   .in5(in32[5]),   .in6(in32[6]),   .in7(in32[7]),
    .in8(in32[8]),   .in9(in32[9]),   .in10(in32[10]), .in11(in32[11]),
    .in12(in32[12]), .in13(in32[13]), .in14(in32[14]), .in15(in32[15]),
    .out(out32), .out_valid(valid32)
  );

  mux_16_reg #(.WIDTH(8)) dut8 (
    .clock(clock), .reset_n(reset_n), .en(en), .select(select),
    .in0(in8[0]),   .in1(in8[1]),   .in2(in8[2]),   .in3(in8[3]),
    .in4(in8[4]),   .in5(in8[5]),   .in6(in8[6]),   .in7(in8[7]),
    .in8(in8[8]),   .in9(in8[9]),   .in10(in8[10]), .in11(in8[11]),
    .in12(in8[12]), .in13(in8[13]), .in14(in8[14]), .in15(in8[15]),
    .out(out8), .out_valid(valid8)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  // Advance past the next rising edge and settle before sampling.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] m_out32;
  logic [7:0]  m_out8;
  logic        m_valid;

  initial begin
    for (int k = 0; k < 16; k++) begin
      in32[k] = 32'(k);
      in8[k]  = 8'hF0 | 8'(k);
    end

    // Asynchronous reset with no clock edge yet.
    reset_n = 1'b0;
    en      = 1'b1;
    select  = 4'd7;
    #1;
    check("rst_async_out",   out32, 32'd0);
    check("rst_async_valid", {31'd0, valid32}, 32'd0);
    step();
    step();
    check("rst_held_out",    out32, 32'd0);
    check("rst_held_valid",  {31'd0, valid32}, 32'd0);
    reset_n = 1'b1;
    step();
    check("rst_release_out",   out32, 32'd7);
    check("rst_release_valid", {31'd0, valid32}, 32'd1);

    // Directed table: full sweep, hold behaviour, same-edge input change.
    for (int i = 0; i < 16; i++)
      vecs.push_back('{en: 1'b1, sel: 4'(i), wr: 1'b0, wr_idx: 4'd0, wr_val: 32'd0,
                       exp_out: 32'(i), exp_valid: 1'b1});
    vecs.push_back('{1'b1, 4'd12, 1'b0, 4'd0,  32'd0,         32'd12,        1'b1});
    vecs.push_back('{1'b0, 4'd3,  1'b1, 4'd12, 32'hDEADBEEF,  32'd12,        1'b0});
    vecs.push_back('{1'b0, 4'd3,  1'b0, 4'd0,  32'd0,         32'd12,        1'b0});
    vecs.push_back('{1'b1, 4'd3,  1'b0, 4'd0,  32'd0,         32'd3,         1'b1});
    vecs.push_back('{1'b1, 4'd4,  1'b1, 4'd12, 32'd12,        32'd4,         1'b1});
    vecs.push_back('{1'b1, 4'd5,  1'b1, 4'd5,  32'hFFFFFFFF,  32'hFFFFFFFF,  1'b1});
    vecs.push_back('{1'b1, 4'd5,  1'b1, 4'd5,  32'd5,         32'd5,         1'b1});

    foreach (vecs[i]) begin
      en     = vecs[i].en;
      select = vecs[i].sel;
      if (vecs[i].wr) in32[vecs[i].wr_idx] = vecs[i].wr_val;
      step();
      check($sformatf("vec%0d_out", i),   out32, vecs[i].exp_out);
      check($sformatf("vec%0d_valid", i), {31'd0, valid32}, {31'd0, vecs[i].exp_valid});
    end

    // Narrow instance: upper nibble pattern proves no truncation/extension.
    en = 1'b1;
    select = 4'd10;
    step();
    check("w8_sel10", {24'd0, out8}, 32'h0000_00FA);
    select = 4'd0;
    step();
    check("w8_sel0",  {24'd0, out8}, 32'h0000_00F0);

    // Reset pulse between edges mid-sweep, then resume on the next edge.
    select = 4'd8;
    step();
    check("mid_pre_out", out32, 32'd8);
    select = 4'd9;
    #2 reset_n = 1'b0;
    #1;
    check("mid_rst_out",   out32, 32'd0);
    check("mid_rst_valid", {31'd0, valid32}, 32'd0);
    check("mid_rst_out8",  {24'd0, out8}, 32'd0);
    #1 reset_n = 1'b1;
    step();
    check("mid_resume_out",   out32, 32'd9);
    check("mid_resume_valid", {31'd0, valid32}, 32'd1);

    // Reset held across an edge: the coincident capture must be discarded.
    select = 4'd11;
    reset_n = 1'b0;
    step();
    check("edge_rst_out", out32, 32'd0);
    reset_n = 1'b1;

    // Randomized traffic against the reference model: out tracks in[sel]
    // whenever en was high at the edge, otherwise keeps its last value.
    m_out32 = 32'd0;
    m_out8  = 8'd0;
    for (int c = 0; c < 300; c++) begin
      en     = ($urandom_range(0, 3) != 0);
      select = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 1) == 1) begin
        int idx;
        idx = $urandom_range(0, 15);
        in32[idx] = $urandom;
        in8[idx]  = 8'($urandom);
      end
      if ($urandom_range(0, 39) == 0) begin
        #1 reset_n = 1'b0;
        #1;
        check($sformatf("rnd%0d_rst", c), {out32[31:1], valid32}, 32'd0);
        reset_n = 1'b1;
        m_out32 = 32'd0;
        m_out8  = 8'd0;
      end
      if (en) begin
        m_out32 = in32[select];
        m_out8  = in8[select];
      end
      m_valid = en;
      step();
      check($sformatf("rnd%0d_out32", c), out32, m_out32);
      check($sformatf("rnd%0d_out8", c),  {24'd0, out8}, {24'd0, m_out8});
      check($sformatf("rnd%0d_valid", c), {30'd0, valid8, valid32}, {30'd0, m_valid, m_valid});
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/mux_16_reg.md
Name: mux_16_reg

Overview:
- Registered 16-to-1 word multiplexer: selects one of sixteen WIDTH-bit inputs by a 4-bit select code and presents it on a registered output.
- Used wherever a register-file read port, ALU result select or similar 16-way choice must be pipelined by one stage.
- Combinational selection is a balanced tree of 2:1 stages (4 levels), followed by an output register with enable and valid flag.

Parameters:
- WIDTH, 32, bit width of every data input and of the output.

Ports:
- clock  input  1  rising-edge clock for all state.
- reset_n  input  1  asynchronous, active-low reset.
- en  input  1  capture enable; when high, the selected input is registered at the next rising edge.
- select  input  4  index of the input to pass (0 selects in0 … 15 selects in15).
- in0 … in15  input  WIDTH each  sixteen data inputs.
- out  output  WIDTH  registered selected data.
- out_valid  output  1  high for the cycle after a capture, i.e. out holds data registered on the previous edge with en=1.

Behaviour:
- Reset: one clock; reset is asynchronous and active-low. While reset_n=0, out=0 and out_valid=0 immediately, independent of clock. Deassertion takes effect at the next rising edge; the first capture can occur on that edge.
- Selection function: sel_data = in[select], with select interpreted as unsigned binary; all 16 codes legal; no default or out-of-range case exists.
- Tree structure: level 1 uses select[0] to pick between in(2k) and in(2k+1); level 2 uses select[1]; level 3 uses select[2]; level 4 uses select[3]. The result is bit-identical to a flat case statement.
- Capture: at each rising edge with reset_n=1:
  - en=1: out <= sel_data; out_valid <= 1.
  - en=0: out holds its value; out_valid <= 0.
- Latency: exactly 1 clock from select/in/en sampled to out updated. There is no combinational path from any input to out.
- Simultaneous changes: values present at the sampling edge are used. Changing select and inputs in the same cycle yields the new input at the new select.
- Holding: out retains its last captured value indefinitely while en=0, including when select or inputs change.
- Reset mid-operation: asserting reset_n=0 at any time clears out and out_valid asynchronously. Any capture due at a coincident edge is discarded.
- Width: no truncation or extension; every output bit j comes from bit j of the selected input.

Test Plan:
- WIDTH=32, in_k=k, en=1: sweep select 0..15, one per cycle -> out equals select value one cycle later (0,1,…,15); out_valid=1 throughout after the first edge.
- Reset: hold reset_n=0 with select=7, en=1 -> out=0 and out_valid=0 with no clock edge. Release reset -> out=7 after the first edge.
- Hold: capture select=12 (out=12), then en=0 and change select to 3 and in12 to 32'hDEADBEEF -> out stays 12 and out_valid=0 until en=1. With en=1, select=3 -> out=3.
- Same-edge change: in5 switches from 5 to 32'hFFFFFFFF in the cycle select changes 4→5 -> out=32'hFFFFFFFF after the edge.
- Asynchronous reset mid-stream: pulse reset_n low between edges during the sweep -> out drops to 0 immediately. The sweep resumes capturing current select on the next edge after release.
- WIDTH=8, in_k = 8'hF0|k: select=10 -> out=8'hFA. select=0 -> out=8'hF0.
